// File: rtl/mux_arb_nx1.sv
// N-to-1 valid/ready multiplexer with external-select (MODE=0) or round-robin (MODE=1)
// arbitration into a single registered output slot.
module mux_arb_nx1 #(
    parameter int unsigned  WIDTH = 8,
    parameter int unsigned  N_IN  = 4,
    parameter int unsigned  MODE  = 1,
    localparam int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer_in;
    int unsigned      idx;

    assign load_en = !out_valid_q || out_ready;

    // Grant depends only on in_valid, sel and ptr -- never on in_data.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (MODE == 0) begin
            if (32'(sel) < N_IN) begin
                if (in_valid[sel]) begin
                    grant_vld = 1'b1;
                    grant_idx = sel;
                end
            end
        end else begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                idx = 32'(ptr_q) + k;
                if (idx >= N_IN) idx = idx - N_IN;
                if (!grant_vld && in_valid[SEL_W'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    assign xfer_in = grant_vld && load_en && rst_n;

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_ready[i] = xfer_in && (grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer_in) begin
            out_data_d  = in_data[32'(grant_idx)*WIDTH +: WIDTH];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (32'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed and scoreboard checks for mux_arb_nx1 in three configurations:
// round-robin N=4, external-select N=3, round-robin N=5/WIDTH=12.
module tb_mux_arb_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    // Round-robin, N_IN=4, WIDTH=8
    logic [31:0] rr_in_data;
    logic [3:0]  rr_in_valid, rr_in_ready;
    logic [1:0]  rr_sel, rr_out_ch;
    logic [7:0]  rr_out_data;
    logic        rr_out_valid, rr_out_ready;

    // External select, N_IN=3, WIDTH=8
    logic [23:0] sl_in_data;
    logic [2:0]  sl_in_valid, sl_in_ready;
    logic [1:0]  sl_sel, sl_out_ch;
    logic [7:0]  sl_out_data;
    logic        sl_out_valid, sl_out_ready;

    // Round-robin, N_IN=5, WIDTH=12
    logic [59:0] rn_in_data;
    logic [4:0]  rn_in_valid, rn_in_ready;
    logic [2:0]  rn_sel, rn_out_ch;
    logic [11:0] rn_out_data;
    logic        rn_out_valid, rn_out_ready;

    mux_arb_nx1 #(.WIDTH(8), .N_IN(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(rr_in_data), .in_valid(rr_in_valid),
        .in_ready(rr_in_ready), .sel(rr_sel), .out_data(rr_out_data), .out_ch(rr_out_ch),
        .out_valid(rr_out_valid), .out_ready(rr_out_ready)
    );

    mux_arb_nx1 #(.WIDTH(8), .N_IN(3), .MODE(0)) u_sl (
        .clk(clk), .rst_n(rst_n), .in_data(sl_in_data), .in_valid(sl_in_valid),
        .in_ready(sl_in_ready), .sel(sl_sel), .out_data(sl_out_data), .out_ch(sl_out_ch),
        .out_valid(sl_out_valid), .out_ready(sl_out_ready)
    );

    mux_arb_nx1 #(.WIDTH(12), .N_IN(5), .MODE(1)) u_rn (
        .clk(clk), .rst_n(rst_n), .in_data(rn_in_data), .in_valid(rn_in_valid),
        .in_ready(rn_in_ready), .sel(rn_sel), .out_data(rn_out_data), .out_ch(rn_out_ch),
        .out_valid(rn_out_valid), .out_ready(rn_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rr_in_data = '0; rr_in_valid = '0; rr_sel = '0; rr_out_ready = 1'b0;
        sl_in_data = '0; sl_in_valid = '0; sl_sel = '0; sl_out_ready = 1'b0;
        rn_in_data = '0; rn_in_valid = '0; rn_sel = '0; rn_out_ready = 1'b0;
    endtask

    // Leaves rst_n high at posedge+1; the next rising edge is the first state update.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        rr_in_valid = 4'hF;
        rr_out_ready = 1'b1;
        tick();
        tick();
        n_tests++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        end
        n_tests++;
        if (rr_in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 0000", rr_in_ready);
        end
        n_tests++;
        if (sl_out_valid !== 1'b0 || rn_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_other_valid: got sl=%b rn=%b expected 0 0",
                     sl_out_valid, rn_out_valid);
        end
    endtask

    task automatic test_rr_all();
        logic [1:0] exp_ch;
        do_reset();
        for (int i = 0; i < 4; i++) rr_in_data[i*8 +: 8] = 8'h10 + 8'(i);
        rr_in_valid  = 4'hF;
        rr_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_ch = 2'(k % 4);
            #1;
            n_tests++;
            if (rr_in_ready !== (4'b0001 << exp_ch)) begin
                n_fail++;
                $display("FAIL rr_all_in_ready[%0d]: got %b expected %b", k, rr_in_ready,
                         4'b0001 << exp_ch);
            end
            tick();
            n_tests++;
            if (rr_out_valid !== 1'b1 || rr_out_ch !== exp_ch ||
                rr_out_data !== 8'h10 + 8'(exp_ch)) begin
                n_fail++;
                $display("FAIL rr_all_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         k, rr_out_valid, rr_out_ch, rr_out_data, exp_ch, 8'h10 + 8'(exp_ch));
            end
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_ch;
        do_reset();
        for (int i = 0; i < 4; i++) rr_in_data[i*8 +: 8] = 8'hA0 + 8'(i);
        rr_in_valid  = 4'b1010;
        rr_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ch = (k % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            n_tests++;
            if (rr_in_ready !== (4'b0001 << exp_ch)) begin
                n_fail++;
                $display("FAIL rr_sparse_in_ready[%0d]: got %b expected %b", k, rr_in_ready,
                         4'b0001 << exp_ch);
            end
            tick();
            n_tests++;
            if (rr_out_valid !== 1'b1 || rr_out_ch !== exp_ch ||
                rr_out_data !== 8'hA0 + 8'(exp_ch)) begin
                n_fail++;
                $display("FAIL rr_sparse_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d",
                         k, rr_out_valid, rr_out_ch, rr_out_data, exp_ch);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sels [4];
        logic [7:0] exp_d [4];
        sels[0] = 2'd0; sels[1] = 2'd1; sels[2] = 2'd2; sels[3] = 2'd0;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h11;
        do_reset();
        sl_in_data   = {8'h33, 8'h22, 8'h11};
        sl_in_valid  = 3'b111;
        sl_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sl_sel = sels[k];
            tick();
            n_tests++;
            if (sl_out_valid !== 1'b1 || sl_out_ch !== sels[k] || sl_out_data !== exp_d[k]) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         k, sl_out_valid, sl_out_ch, sl_out_data, sels[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        sl_in_data   = {8'hA5, 8'h22, 8'h11};
        sl_in_valid  = 3'b111;
        sl_sel       = 2'd2;
        sl_out_ready = 1'b0;
        #1;
        n_tests++;
        if (sl_in_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL stall_first_ready: got %b expected 100", sl_in_ready);
        end
        tick();
        sl_in_data[16 +: 8] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (sl_in_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 000", k, sl_in_ready);
            end
            n_tests++;
            if (sl_out_valid !== 1'b1 || sl_out_data !== 8'hA5 || sl_out_ch !== 2'd2) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
                         k, sl_out_valid, sl_out_data, sl_out_ch);
            end
            tick();
        end
        sl_in_valid  = 3'b000;
        sl_out_ready = 1'b1;
        tick();
        n_tests++;
        if (sl_out_valid !== 1'b0 || sl_out_data !== 8'hA5 || sl_out_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_drain: got v=%b d=%h ch=%0d expected v=0 d=a5 ch=2",
                     sl_out_valid, sl_out_data, sl_out_ch);
        end
    endtask

    task automatic test_sel_oob();
        do_reset();
        sl_in_data   = {8'h33, 8'h22, 8'h11};
        sl_in_valid  = 3'b111;
        sl_sel       = 2'd3;
        sl_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (sl_in_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL oob_in_ready[%0d]: got %b expected 000", k, sl_in_ready);
            end
            tick();
            n_tests++;
            if (sl_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL oob_out_valid[%0d]: got %b expected 0", k, sl_out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) rr_in_data[i*8 +: 8] = 8'h40 + 8'(i);
        rr_in_valid  = 4'hF;
        rr_out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (rr_out_valid !== 1'b0 || rr_out_data !== 8'h00 || rr_out_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset_out: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                     rr_out_valid, rr_out_data, rr_out_ch);
        end
        n_tests++;
        if (rr_in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_in_ready: got %b expected 0000", rr_in_ready);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (rr_in_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_release_ready: got %b expected 0001", rr_in_ready);
        end
        tick();
        n_tests++;
        if (rr_out_valid !== 1'b1 || rr_out_ch !== 2'd0 || rr_out_data !== 8'h40) begin
            n_fail++;
            $display("FAIL async_release_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=40",
                     rr_out_valid, rr_out_ch, rr_out_data);
        end
    endtask

    task automatic test_random();
        logic [14:0] sb [$];
        logic [14:0] exp_w;
        logic        stall_prev;
        logic [11:0] held_d;
        logic [2:0]  held_ch;
        do_reset();
        stall_prev = 1'b0;
        held_d     = '0;
        held_ch    = '0;
        for (int cyc = 0; cyc < 2003; cyc++) begin
            if (stall_prev) begin
                n_tests++;
                if (rn_out_valid !== 1'b1 || rn_out_data !== held_d || rn_out_ch !== held_ch) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                             cyc, rn_out_valid, rn_out_data, rn_out_ch, held_d, held_ch);
                end
            end
            if (cyc < 2000) begin
                rn_in_valid  = 5'($urandom);
                rn_out_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 5; i++) rn_in_data[i*12 +: 12] = 12'($urandom);
            end else begin
                rn_in_valid  = '0;
                rn_out_ready = 1'b1;
            end
            #1;
            n_tests++;
            if ($countones(rn_in_ready) > 1 || (rn_in_ready & ~rn_in_valid) != 5'b0) begin
                n_fail++;
                $display("FAIL rnd_in_ready[%0d]: got %b with valid %b expected one-hot subset",
                         cyc, rn_in_ready, rn_in_valid);
            end
            if (rn_out_valid && !rn_out_ready) begin
                n_tests++;
                if (rn_in_ready !== 5'b0) begin
                    n_fail++;
                    $display("FAIL rnd_stall_ready[%0d]: got %b expected 00000", cyc, rn_in_ready);
                end
            end
            if (rn_out_valid && rn_out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_dup[%0d]: got ch=%0d d=%h expected no word", cyc,
                             rn_out_ch, rn_out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({rn_out_ch, rn_out_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL rnd_order[%0d]: got ch=%0d d=%h expected ch=%0d d=%h",
                                 cyc, rn_out_ch, rn_out_data, exp_w[14:12], exp_w[11:0]);
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                if (rn_in_ready[i] && rn_in_valid[i]) sb.push_back({3'(i), rn_in_data[i*12 +: 12]});
            end
            stall_prev = rn_out_valid && !rn_out_ready;
            held_d     = rn_out_data;
            held_ch    = rn_out_ch;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (sb.size() != 0 || rn_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_loss: got %0d pending, v=%b expected 0 pending, v=0",
                     sb.size(), rn_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_rr_sparse();
        test_back_to_back();
        test_stall();
        test_sel_oob();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
